// File: rtl/s2mm_packet_arbiter_if.sv
// Bundle of every signal between the packet arbiter and its surroundings:
// the AXI-Stream sink toward the MCDMA S2MM engine and the per-channel FIFO heads.
// The arbiter connects through the master modport and the surroundings through slave.
interface s2mm_packet_arbiter_if #(
    parameter int NUM_CHANNELS    = 4,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) ();
    logic                                    SINK_AXIS_tready_in;
    logic [AXIS_DATA_WIDTH-1:0]              SINK_AXIS_tdata_out;
    logic [AXIS_DEST_WIDTH-1:0]              SINK_AXIS_tdest_out;
    logic [AXIS_KEEP_WIDTH-1:0]              SINK_AXIS_tkeep_out;
    logic                                    SINK_AXIS_tlast_out;
    logic                                    SINK_AXIS_tuser_out;
    logic                                    SINK_AXIS_tvalid_out;
    logic [NUM_CHANNELS*FIFO_DATA_WIDTH-1:0] fifo_data_in;
    logic [NUM_CHANNELS-1:0]                 fifo_not_empty_in;
    logic [NUM_CHANNELS-1:0]                 fifo_last_in;
    logic [NUM_CHANNELS-1:0]                 fifo_r_stb_out;
    logic [NUM_CHANNELS-1:0]                 channel_mask_in;
    logic [NUM_CHANNELS*32-1:0]              pkt_count_out;

    modport master (
        input  SINK_AXIS_tready_in, fifo_data_in, fifo_not_empty_in, fifo_last_in,
               channel_mask_in,
        output SINK_AXIS_tdata_out, SINK_AXIS_tdest_out, SINK_AXIS_tkeep_out,
               SINK_AXIS_tlast_out, SINK_AXIS_tuser_out, SINK_AXIS_tvalid_out,
               fifo_r_stb_out, pkt_count_out
    );

    modport slave (
        output SINK_AXIS_tready_in, fifo_data_in, fifo_not_empty_in, fifo_last_in,
               channel_mask_in,
        input  SINK_AXIS_tdata_out, SINK_AXIS_tdest_out, SINK_AXIS_tkeep_out,
               SINK_AXIS_tlast_out, SINK_AXIS_tuser_out, SINK_AXIS_tvalid_out,
               fifo_r_stb_out, pkt_count_out
    );
endinterface

// File: rtl/s2mm_packet_arbiter.sv
// Round-robin packet arbiter: merges per-channel FWFT FIFOs into one AXI-Stream,
// keeping each packet contiguous and tagging it with its channel on tdest.
// Optional per-channel completed-packet counters: define S2MM_PACKET_ARBITER_STATS_EN.
//
// state | meaning
// IDLE  | no grant; pick next eligible channel cyclically after last_q
// BUSY  | channel grant_q owns the stream until its tlast word is loaded
module s2mm_packet_arbiter #(
    parameter int NUM_CHANNELS    = 4,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    s2mm_packet_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_CHANNELS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           grant_q, grant_d;
    logic [IDX_W-1:0]           last_q, last_d;
    logic [IDX_W-1:0]           sel_idx;
    logic                       found;
    logic                       load;
    logic [NUM_CHANNELS-1:0]    stb;
    logic [FIFO_DATA_WIDTH-1:0] head_word;
    logic                       head_valid;
    logic                       head_last;

    logic                       tvalid_q;
    logic                       tlast_q;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q;
    logic [AXIS_DEST_WIDTH-1:0] tdest_q;

    // Head of the granted FIFO.
    always_comb begin
        head_word = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                head_word = bus.fifo_data_in[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
            end
        end
        head_valid = bus.fifo_not_empty_in[grant_q];
        head_last  = bus.fifo_last_in[grant_q];
    end

    // Cyclic search for the first eligible channel after the last served one.
    always_comb begin : p_search
        int idx;
        idx     = 0;
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            idx = (int'(last_q) + k) % NUM_CHANNELS;
            if (!found && bus.fifo_not_empty_in[idx] && bus.channel_mask_in[idx]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(idx);
            end
        end
    end

    // Next-state, grant bookkeeping and the pop strobe.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        load    = 1'b0;
        stb     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    grant_d = sel_idx;
                end
            end
            BUSY: begin
                load = (!tvalid_q || bus.SINK_AXIS_tready_in) && head_valid;
                if (load) begin
                    stb[grant_q] = 1'b1;
                    if (head_last) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // The state register may still hold stale BUSY during the first reset cycle.
        if (rst_in) begin
            stb = '0;
        end
    end

    // FSM state, grant and round-robin pointer registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CHANNELS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Output register: load a popped word, or drop tvalid once it is taken.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tdest_q  <= '0;
        end else if (load) begin
            tvalid_q <= 1'b1;
            tlast_q  <= head_last;
            tdata_q  <= AXIS_DATA_WIDTH'(head_word);
            tdest_q  <= AXIS_DEST_WIDTH'(grant_q);
        end else if (tvalid_q && bus.SINK_AXIS_tready_in) begin
            tvalid_q <= 1'b0;
        end
    end

    assign bus.fifo_r_stb_out       = stb;
    assign bus.SINK_AXIS_tvalid_out = tvalid_q;
    assign bus.SINK_AXIS_tlast_out  = tlast_q;
    assign bus.SINK_AXIS_tdata_out  = tdata_q;
    assign bus.SINK_AXIS_tdest_out  = tdest_q;
    assign bus.SINK_AXIS_tkeep_out  = '1;
    assign bus.SINK_AXIS_tuser_out  = 1'b0;

`ifdef S2MM_PACKET_ARBITER_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_CHANNELS];

    // Count packets as their last word is accepted downstream.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else if (tvalid_q && bus.SINK_AXIS_tready_in && tlast_q) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (tdest_q == AXIS_DEST_WIDTH'(i)) begin
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_cnt
        assign bus.pkt_count_out[g*32 +: 32] = pkt_cnt_q[g];
    end
`else
    assign bus.pkt_count_out = '0;
`endif
endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// Bench for s2mm_packet_arbiter: the bench owns the channel FIFOs as queues, a
// transaction-level model predicts strobes and the output stream every cycle, and
// directed scenarios pin the model with hand-computed grant orders and data.
module tb_s2mm_packet_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    s2mm_packet_arbiter_if #(.NUM_CHANNELS(N), .FIFO_DATA_WIDTH(W), .AXIS_DATA_WIDTH(32),
                             .AXIS_DEST_WIDTH(4), .AXIS_KEEP_WIDTH(4)) bus ();

    s2mm_packet_arbiter #(.NUM_CHANNELS(N), .FIFO_DATA_WIDTH(W), .AXIS_DATA_WIDTH(32),
                          .AXIS_DEST_WIDTH(4), .AXIS_KEEP_WIDTH(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_data [N][$];
    bit          q_last [N][$];
    logic [N-1:0] pop_pend = '0;
    bit          chk_en = 1'b0;
    int          cyc = 0;

    // model state
    bit          m_busy  = 1'b0;
    int          m_grant = 0;
    int          m_ptr   = N - 1;
    bit          m_v     = 1'b0;
    bit          m_last  = 1'b0;
    logic [31:0] m_data  = '0;
    int          m_dest  = 0;
    logic [31:0] m_cnt [N] = '{default: 0};

    // accepted-word log from the model
    int          acc_dest [$];
    logic [31:0] acc_data [$];
    bit          acc_last [$];
    int          acc_cyc  [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        for (int c = 0; c < N; c++) begin
            if (q_data[c].size() > 0) begin
                bus.fifo_data_in[c*W +: W] = q_data[c][0];
                bus.fifo_not_empty_in[c]   = 1'b1;
                bus.fifo_last_in[c]        = q_last[c][0];
            end else begin
                bus.fifo_data_in[c*W +: W] = '0;
                bus.fifo_not_empty_in[c]   = 1'b0;
                bus.fifo_last_in[c]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int c, input logic [31:0] d, input bit l);
        q_data[c].push_back(d);
        q_last[c].push_back(l);
        drive_fifo();
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
        for (int c = 0; c < N; c++) begin
            if (pop_pend[c] && q_data[c].size() > 0) begin
                void'(q_data[c].pop_front());
                void'(q_last[c].pop_front());
            end
        end
        drive_fifo();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        for (int c = 0; c < N; c++) begin
            q_data[c].delete();
            q_last[c].delete();
        end
        drive_fifo();
        repeat (2) cycle();
        rst_in = 1'b0;
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk_in) begin
        logic [N-1:0] exp_stb;
        logic [127:0] exp_cnt;
        bit           ld;
        bit           hs;
        bit           got;
        int           c;
        if (chk_en) begin
            cyc++;
            exp_stb = '0;
            ld      = 1'b0;
            if (!rst_in && m_busy && (!m_v || bus.SINK_AXIS_tready_in) &&
                bus.fifo_not_empty_in[m_grant]) begin
                ld = 1'b1;
                exp_stb[m_grant] = 1'b1;
            end
            for (int i = 0; i < N; i++) exp_cnt[i*32 +: 32] = m_cnt[i];
            check("strobe", bus.fifo_r_stb_out, exp_stb);
            check("tvalid", bus.SINK_AXIS_tvalid_out, m_v);
            if (m_v) begin
                check("tdata", bus.SINK_AXIS_tdata_out, m_data);
                check("tdest", bus.SINK_AXIS_tdest_out, m_dest);
                check("tlast", bus.SINK_AXIS_tlast_out, m_last);
            end
            check("tkeep", bus.SINK_AXIS_tkeep_out, 4'hF);
            check("tuser", bus.SINK_AXIS_tuser_out, 1'b0);
            check("pkt_count", bus.pkt_count_out, exp_cnt);

            hs = m_v && bus.SINK_AXIS_tready_in;
            if (rst_in) begin
                m_busy = 1'b0; m_grant = 0; m_ptr = N - 1;
                m_v = 1'b0; m_last = 1'b0; m_data = '0; m_dest = 0;
                for (int i = 0; i < N; i++) m_cnt[i] = '0;
            end else begin
                if (hs) begin
                    acc_dest.push_back(m_dest);
                    acc_data.push_back(m_data);
                    acc_last.push_back(m_last);
                    acc_cyc.push_back(cyc);
`ifdef S2MM_PACKET_ARBITER_STATS_EN
                    if (m_last) m_cnt[m_dest] = m_cnt[m_dest] + 32'd1;
`endif
                end
                if (ld) begin
                    m_v    = 1'b1;
                    m_data = bus.fifo_data_in[m_grant*W +: W];
                    m_dest = m_grant;
                    m_last = bus.fifo_last_in[m_grant];
                end else if (hs) begin
                    m_v = 1'b0;
                end
                if (!m_busy) begin
                    got = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_ptr + k) % N;
                        if (!got && bus.fifo_not_empty_in[c] && bus.channel_mask_in[c]) begin
                            got = 1'b1;
                            m_busy = 1'b1;
                            m_grant = c;
                        end
                    end
                end else if (ld && bus.fifo_last_in[m_grant]) begin
                    m_busy = 1'b0;
                    m_ptr  = m_grant;
                end
            end
        end
        pop_pend = bus.fifo_r_stb_out;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int w;
        int t1_dest [6];
        logic [31:0] t1_data [6];
        bit t1_last [6];
        int t2_dest [5];
        int t3_dest [5];
        logic [31:0] t3_data [5];
        bit t3_last [5];
        t1_dest = '{0, 0, 0, 2, 2, 2};
        t1_data = '{32'h100, 32'h101, 32'h102, 32'h200, 32'h201, 32'h202};
        t1_last = '{0, 0, 1, 0, 0, 1};
        t2_dest = '{0, 1, 2, 3, 0};
        t3_dest = '{1, 1, 1, 1, 3};
        t3_data = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h31};
        t3_last = '{0, 0, 0, 1, 1};

        bus.SINK_AXIS_tready_in = 1'b1;
        bus.channel_mask_in     = '1;
        drive_fifo();
        rst_in = 1'b1;
        cycle();
        chk_en = 1'b1;
        cycle();
        check("reset_tvalid", bus.SINK_AXIS_tvalid_out, 1'b0);
        check("reset_strobe", bus.fifo_r_stb_out, '0);
        check("reset_count", bus.pkt_count_out, '0);
        cycle();
        rst_in = 1'b0;

        // two 3-word packets on ch0 and ch2
        base = acc_dest.size();
        push(0, 32'h100, 0); push(0, 32'h101, 0); push(0, 32'h102, 1);
        push(2, 32'h200, 0); push(2, 32'h201, 0); push(2, 32'h202, 1);
        repeat (14) cycle();
        check("t1_count", acc_dest.size() - base, 6);
        if (acc_dest.size() - base == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t1_dest", acc_dest[base+i], t1_dest[i]);
                check("t1_data", acc_data[base+i], t1_data[i]);
                check("t1_last", acc_last[base+i], t1_last[i]);
            end
            check("t1_back_to_back", acc_cyc[base+1] - acc_cyc[base], 1);
            check("t1_one_bubble", acc_cyc[base+3] - acc_cyc[base+2], 2);
        end

        // one-word packets on every channel: strict rotation
        do_reset();
        base = acc_dest.size();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < N; c++) push(c, 32'h1000 + c * 16 + r, 1);
        repeat (34) cycle();
        check("t2_count", acc_dest.size() - base, 12);
        if (acc_dest.size() - base >= 5)
            for (int i = 0; i < 5; i++) check("t2_order", acc_dest[base+i], t2_dest[i]);

        // ch1 stalls mid-packet while ch3 waits
        do_reset();
        base = acc_dest.size();
        push(1, 32'h11, 0); push(1, 32'h12, 0); push(3, 32'h31, 1);
        repeat (8) cycle();
        check("t3_stall_words", acc_dest.size() - base, 2);
        push(1, 32'h13, 0); push(1, 32'h14, 1);
        repeat (10) cycle();
        check("t3_count", acc_dest.size() - base, 5);
        if (acc_dest.size() - base == 5)
            for (int i = 0; i < 5; i++) begin
                check("t3_dest", acc_dest[base+i], t3_dest[i]);
                check("t3_data", acc_data[base+i], t3_data[i]);
                check("t3_last", acc_last[base+i], t3_last[i]);
            end

        // backpressure hold
        do_reset();
        base = acc_dest.size();
        bus.SINK_AXIS_tready_in = 1'b0;
        push(0, 32'hA5A5A5A5, 1); push(0, 32'h5A, 1);
        w = 0;
        while (!bus.SINK_AXIS_tvalid_out && w < 10) begin
            cycle();
            w++;
        end
        check("t4_valid_seen", bus.SINK_AXIS_tvalid_out, 1'b1);
        repeat (3) begin
            cycle();
            check("t4_hold_data", bus.SINK_AXIS_tdata_out, 32'hA5A5A5A5);
            check("t4_hold_valid", bus.SINK_AXIS_tvalid_out, 1'b1);
            check("t4_no_strobe", bus.fifo_r_stb_out, '0);
        end
        bus.SINK_AXIS_tready_in = 1'b1;
        repeat (8) cycle();
        check("t4_count", acc_dest.size() - base, 2);
        if (acc_dest.size() - base == 2) begin
            check("t4_first", acc_data[base], 32'hA5A5A5A5);
            check("t4_second", acc_data[base+1], 32'h5A);
        end

        // mask gating
        bus.channel_mask_in = 4'b1011;
        do_reset();
        base = acc_dest.size();
        push(2, 32'h77, 1);
        repeat (4) cycle();
        check("t5_masked_idle", bus.SINK_AXIS_tvalid_out, 1'b0);
        check("t5_masked_count", acc_dest.size() - base, 0);
        bus.channel_mask_in = '1;
        cycle();
        check("t5_grant_strobe", bus.fifo_r_stb_out, 4'b0100);
        repeat (4) cycle();
        check("t5_count", acc_dest.size() - base, 1);
        if (acc_dest.size() - base == 1) check("t5_data", acc_data[base], 32'h77);

        // packet counters and mid-packet reset
        do_reset();
        for (int i = 0; i < 5; i++) push(3, 32'h300 + i, 1);
        repeat (15) cycle();
`ifdef S2MM_PACKET_ARBITER_STATS_EN
        check("t6_cnt3", bus.pkt_count_out[3*32 +: 32], 5);
        check("t6_cnt_others", bus.pkt_count_out[95:0], '0);
`else
        check("t6_cnt_off", bus.pkt_count_out, '0);
`endif
        for (int i = 0; i < 6; i++) push(1, 32'hB0 + i, i == 5);
        repeat (4) cycle();
        check("t6_mid_valid", bus.SINK_AXIS_tvalid_out, 1'b1);
        rst_in = 1'b1;
        for (int c = 0; c < N; c++) begin
            q_data[c].delete();
            q_last[c].delete();
        end
        drive_fifo();
        cycle();
        check("t6_rst_valid", bus.SINK_AXIS_tvalid_out, 1'b0);
        check("t6_rst_count", bus.pkt_count_out, '0);
        rst_in = 1'b0;
        repeat (3) cycle();
        check("t6_after_valid", bus.SINK_AXIS_tvalid_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
